// File: rtl/replay_ctrl.sv
// Purpose: records a stream of words into an 8-entry sram ring and replays them, oldest first, on request.
// Latency: the first replayed word is valid in the third cycle after replay_start is taken; words then follow one every 3 cycles.
// Backpressure: in_ready drops while a replay runs; a presented word holds on out_* until out_ready accepts it.
//
// Ports:
//   clk, rst                   - single clock, synchronous active-high reset
//   in_data/in_valid/in_ready  - record stream (accepted only while idle)
//   replay_start               - one-cycle replay request (ignored when busy or empty)
//   out_data/out_valid/out_ready/out_last - replay stream, out_last on the final word
//   busy, count                - replay in progress, stored word count 0..8
//   sram_*                     - 8x16 sram: combinational write port, registered read port
module replay_ctrl #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             replay_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [AW:0]      count,
  output logic [AW-1:0]    sram_w_addr,
  output logic [WIDTH-1:0] sram_din,
  output logic             sram_we,
  output logic             sram_oe,
  output logic [AW-1:0]    sram_r_addr,
  input  logic [WIDTH-1:0] sram_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, PRESENT} state_t;

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      remaining_q, remaining_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic [AW-1:0]    sram_r_addr_q, sram_r_addr_d;
  logic             sram_oe_q, sram_oe_d;
  logic [AW-1:0]    oldest;

  // Write side is purely combinational so a word lands in the sram on the edge it is accepted.
  assign in_ready    = (state_q == IDLE) && !rst;
  assign sram_we     = in_valid && in_ready;
  assign sram_w_addr = wr_ptr_q;
  assign sram_din    = in_data;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    sram_oe_d   = 1'b0;

    if (sram_we) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q != DEPTH) count_d = count_q + ONE;
    end

    // Oldest entry after this edge's write, so a simultaneous write joins the replay.
    // A full ring (count=8) truncates to 0 here, making the oldest slot the one about to be overwritten next.
    oldest = wr_ptr_d - count_d[AW-1:0];

    case (state_q)
      IDLE: begin
        if (replay_start && (count_d != '0)) begin
          rd_ptr_d    = oldest;
          remaining_d = count_d;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Address has been stable through ISSUE; open the sram output for the capture cycle.
        sram_oe_d = 1'b1;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        out_data_d  = sram_dout;
        out_valid_d = 1'b1;
        out_last_d  = (remaining_q == ONE);
        state_d     = PRESENT;
      end
      PRESENT: begin
        out_valid_d = 1'b1;
        out_last_d  = out_last_q;
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          remaining_d = remaining_q - ONE;
          rd_ptr_d    = rd_ptr_q + AW'(1);
          state_d     = (remaining_q == ONE) ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    sram_r_addr_d = rd_ptr_d;
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      remaining_q   <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      sram_r_addr_q <= '0;
      sram_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      remaining_q   <= remaining_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      sram_r_addr_q <= sram_r_addr_d;
      sram_oe_q     <= sram_oe_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign count       = count_q;
  assign sram_r_addr = sram_r_addr_q;
  assign sram_oe     = sram_oe_q;

endmodule

// File: tb/tb_replay_ctrl.sv
// Purpose: self-checking bench for replay_ctrl with a behavioural 8x16 sram and a scoreboard of expected replay words.
// Latency: expected words are queued when a replay is requested and compared as the DUT hands them out.
// Backpressure: out_ready is driven by the test sequence; the monitor only compares on accepted words.
module tb_replay_ctrl;

  typedef struct {
    logic [15:0] dat;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        replay_start;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic [3:0]  count;
  logic [2:0]  sram_w_addr;
  logic [15:0] sram_din;
  logic        sram_we;
  logic        sram_oe;
  logic [2:0]  sram_r_addr;
  logic [15:0] sram_dout;

  always #5 clk = ~clk;

  replay_ctrl #(.WIDTH(16), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .replay_start(replay_start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .count(count),
    .sram_w_addr(sram_w_addr), .sram_din(sram_din), .sram_we(sram_we),
    .sram_oe(sram_oe), .sram_r_addr(sram_r_addr), .sram_dout(sram_dout)
  );

  // Behavioural sram: address registered on the edge, data visible only while oe=1 and we=0.
  logic [15:0] mem [8];
  logic [15:0] rd_q;
  always @(posedge clk) begin
    if (sram_we) mem[sram_w_addr] <= sram_din;
    rd_q <= mem[sram_r_addr];
  end
  assign sram_dout = (sram_oe && !sram_we) ? rd_q : 16'hDEAD;

  int checks   = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference contents of the ring.
  logic [15:0] m_mem [8];
  int          m_wr;
  int          m_cnt;
  exp_t        sb [$];

  int cyc = 0;
  int prev_cyc;
  bit have_prev;
  bit spacing_en;

  always @(posedge clk) cyc++;

  // Compare each accepted word against the scoreboard head; with out_ready held high, words arrive 3 cycles apart.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk_eq("unexpected_vld", {31'b0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk_eq("out_data", {16'b0, out_data}, {16'b0, e.dat});
        chk_eq("out_last", {31'b0, out_last}, {31'b0, e.last});
        if (spacing_en && have_prev) chk_eq("spacing", cyc - prev_cyc, 3);
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [15:0] d);
    m_mem[m_wr] = d;
    m_wr = (m_wr + 1) % 8;
    if (m_cnt < 8) m_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    replay_start = 1'b0;
    out_ready = 1'b1;
    in_data = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    m_wr = 0;
    m_cnt = 0;
    sb.delete();
    have_prev = 1'b0;
    spacing_en = 1'b1;
  endtask

  task automatic write_word(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    model_write(d);
  endtask

  task automatic start_replay(input bit with_write, input logic [15:0] d);
    replay_start = 1'b1;
    if (with_write) begin
      in_valid = 1'b1;
      in_data  = d;
    end
    step();
    replay_start = 1'b0;
    in_valid = 1'b0;
    if (with_write) model_write(d);
    have_prev = 1'b0;
    for (int i = 0; i < m_cnt; i++) begin
      exp_t e;
      e.dat  = m_mem[(m_wr - m_cnt + i + 8) % 8];
      e.last = (i == m_cnt - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      step();
      n++;
    end
    chk_eq({tag, "_drained"}, sb.size(), 0);
    chk_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // Reset state.
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h1234;
    replay_start = 1'b0;
    out_ready = 1'b1;
    #1;
    chk_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk_eq("rst_sram_we", {31'b0, sram_we}, 32'd0);
    do_reset();
    chk_eq("rst_count", {28'b0, count}, 32'd0);
    chk_eq("rst_busy", {31'b0, busy}, 32'd0);
    chk_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk_eq("rst_out_last", {31'b0, out_last}, 32'd0);
    chk_eq("rst_sram_oe", {31'b0, sram_oe}, 32'd0);
    chk_eq("rst_r_addr", {29'b0, sram_r_addr}, 32'd0);
    chk_eq("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Four words replayed in order; first word in the third cycle after the start edge.
    write_word(16'd10);
    write_word(16'd20);
    write_word(16'd30);
    write_word(16'd50);
    chk_eq("cnt4_before", {28'b0, count}, 32'd4);
    start_replay(1'b0, 16'd0);
    chk_eq("busy_after_start", {31'b0, busy}, 32'd1);
    chk_eq("in_ready_busy", {31'b0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk_eq("first_latency", lat, 3);
    wait_done("four");
    chk_eq("cnt4_after", {28'b0, count}, 32'd4);

    // Empty replay is ignored.
    do_reset();
    replay_start = 1'b1;
    step();
    replay_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_eq("empty_busy", {31'b0, busy}, 32'd0);
      chk_eq("empty_vld", {31'b0, out_valid}, 32'd0);
      step();
    end

    // Overflow: ten writes keep the newest eight, replayed from 3.
    do_reset();
    for (int i = 1; i <= 10; i++) write_word(16'(i));
    chk_eq("cnt_sat", {28'b0, count}, 32'd8);
    start_replay(1'b0, 16'd0);
    wait_done("wrap");
    chk_eq("cnt_sat_after", {28'b0, count}, 32'd8);

    // Backpressure on the first of two words.
    do_reset();
    write_word(16'hA1);
    write_word(16'hA2);
    out_ready = 1'b0;
    start_replay(1'b0, 16'd0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      chk_eq("hold_vld", {31'b0, out_valid}, 32'd1);
      chk_eq("hold_data", {16'b0, out_data}, {16'b0, sb[0].dat});
      chk_eq("hold_in_ready", {31'b0, in_ready}, 32'd0);
      step();
    end
    spacing_en = 1'b0;
    out_ready = 1'b1;
    wait_done("hold");

    // Write and replay_start on the same edge: the new word joins the replay.
    do_reset();
    write_word(16'd5);
    start_replay(1'b1, 16'd7);
    wait_done("same_edge");
    chk_eq("same_edge_cnt", {28'b0, count}, 32'd2);

    // Reset during CAPTURE aborts the replay.
    do_reset();
    for (int i = 0; i < 4; i++) write_word(16'(16'h40 + i));
    start_replay(1'b0, 16'd0);
    step();
    chk_eq("capture_oe", {31'b0, sram_oe}, 32'd1);
    rst = 1'b1;
    sb.delete();
    step();
    chk_eq("abort_vld", {31'b0, out_valid}, 32'd0);
    chk_eq("abort_busy", {31'b0, busy}, 32'd0);
    chk_eq("abort_cnt", {28'b0, count}, 32'd0);
    chk_eq("abort_oe", {31'b0, sram_oe}, 32'd0);
    rst = 1'b0;
    m_wr = 0;
    m_cnt = 0;
    #1;
    chk_eq("abort_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk_eq("abort_no_vld", {31'b0, out_valid}, 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/replay_ctrl.md
REPLAY_CTRL -- requirements
Module: replay_ctrl

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 16, data word width.
- AW, default 3, sram address width; depth = 2**AW = 8.
- The block SHALL be used only with the defaults, to match the 8x16 sram.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  16  word to record.
- in_valid  in  1  in_data offered.
- in_ready  out  1  word accepted when in_valid & in_ready.
- replay_start  in  1  one-cycle request to replay stored words.
- out_data  out  16  replayed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_last  out  1  qualifies the final word of a replay.
- busy  out  1  replay in progress.
- count  out  4  stored words, 0..8.
- sram_w_addr  out  3  sram write address.
- sram_din  out  16  sram write data.
- sram_we  out  1  sram write enable.
- sram_oe  out  1  sram output enable.
- sram_r_addr  out  3  sram read address.
- sram_dout  in  16  sram read data; registered, 1-cycle read latency, valid only while we=0 and oe=1.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, CAPTURE, PRESENT.

REQ-004 in_ready SHALL be 1 only in IDLE with rst=0, and 0 in all other states.

REQ-005 Write path SHALL be combinational: sram_we = in_valid & in_ready; sram_w_addr = wr_ptr; sram_din = in_data.

REQ-006 On each accepted word:
- wr_ptr SHALL increment modulo 8.
- count SHALL increment, saturating at 8.
- At count=8 the oldest entry SHALL be overwritten, which advances the oldest index.

REQ-007 The oldest index SHALL be (wr_ptr - count) mod 8.

REQ-008 replay_start in IDLE with post-edge count>0 SHALL:
- snapshot remaining = post-edge count;
- set rd_ptr = post-edge oldest index;
- enter ISSUE.

REQ-009 replay_start with post-edge count=0, or outside IDLE, SHALL be ignored.

REQ-010 If in_valid and replay_start are asserted together in IDLE:
- the write SHALL commit on that edge;
- the replay SHALL include the new word.

REQ-011 ISSUE: sram_r_addr SHALL be driven with rd_ptr, sram_oe=0; next state SHALL be CAPTURE.

REQ-012 CAPTURE: sram_oe=1 and sram_we=0; out_data SHALL load sram_dout at the edge; next state SHALL be PRESENT.

REQ-013 PRESENT behaviour:
- out_valid=1, with out_data held stable until accepted.
- out_last=1 iff remaining=1.

REQ-014 On acceptance in PRESENT:
- remaining SHALL decrement and rd_ptr SHALL increment modulo 8.
- If remaining was 1, next state SHALL be IDLE; otherwise ISSUE.

REQ-015 Throughput SHALL be one word per 3 cycles when out_ready=1. First out_valid SHALL occur 3 cycles after the replay_start edge.

REQ-016 Replay SHALL be non-destructive: count and wr_ptr SHALL be unchanged by a replay.

REQ-017 Output conditions:
- busy = (state != IDLE).
- sram_oe SHALL be 0 outside CAPTURE.
- out_valid and out_last SHALL be 0 outside PRESENT.

Reset
REQ-018 While rst=1, on the clock edge the block SHALL set:
- state=IDLE, wr_ptr=0, rd_ptr=0, remaining=0, count=0;
- out_data=0, out_valid=0, out_last=0, busy=0;
- sram_r_addr=0, sram_oe=0.
While rst=1, in_ready=0, and therefore sram_we=0.

REQ-019 Reset asserted mid-replay SHALL abort the replay immediately. No further out_valid SHALL occur, and sram contents become inaccessible because count=0.

Verification
REQ-020 Write 10, 20, 30, 50; pulse replay_start; out_ready=1 -> out_data sequence 10, 20, 30, 50, each word 3 cycles apart; out_last only on 50; count=4 after.

REQ-021 Write 1..10 -> count=8; replay -> 3, 4, 5, 6, 7, 8, 9, 10; out_last on 10.

REQ-022 replay_start with count=0 -> busy stays 0; no out_valid.

REQ-023 Replay of 2 words; hold out_ready=0 for 5 cycles on the first word -> out_data stable, out_valid held, in_ready=0 throughout; after release, both words delivered in order.

REQ-024 Write 7 and replay_start in the same cycle with count=1 holding 5 -> replay 5, then 7; count=2.

REQ-025 Assert rst during CAPTURE of a 4-word replay -> next cycle out_valid=0, busy=0, count=0, in_ready=1 after rst is released.
